divider_unit: RTL and testbench

DIVIDER_UNIT -- requirements
Module: divider_unit

---
 rtl/divider_unit.sv | 112 +++++++++++
 tb/tb_divider_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/divider_unit.sv
// Iterative restoring divider: one quotient bit per clock, MSB first, WIDTH cycles per op.
// Define DIVIDER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module divider_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc, qr, dvs;
    logic [WIDTH:0]   sh, diff;
    logic [WIDTH-1:0] acc_nxt, q_fin, q_out, r_out, a_mag, b_mag;
    logic             qbit, last;

`ifdef DIVIDER_SIGNED_EN
    logic neg_q, neg_r;
    assign a_mag = Dividend[WIDTH-1] ? -Dividend : Dividend;
    assign b_mag = Divisor[WIDTH-1]  ? -Divisor  : Divisor;
    assign q_out = neg_q ? -q_fin   : q_fin;
    assign r_out = neg_r ? -acc_nxt : acc_nxt;
`else
    assign a_mag = Dividend;
    assign b_mag = Divisor;
    assign q_out = q_fin;
    assign r_out = acc_nxt;
`endif

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign sh      = {acc, qr[WIDTH-1]};
    assign diff    = sh - {1'b0, dvs};
    assign qbit    = ~diff[WIDTH];
    assign acc_nxt = qbit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
    assign q_fin   = {qr[WIDTH-2:0], qbit};
    assign last    = (cnt == CW'(WIDTH - 1));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (Divisor == '0) ? DONE : CALC;
            CALC: if (last)  state_nxt = DONE;
            DONE:            state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            qr        <= '0;
            dvs       <= '0;
            Quotient  <= '0;
            Remainder <= '0;
            DivZero   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt     <= '0;
                    acc     <= '0;
                    qr      <= a_mag;
                    dvs     <= b_mag;
                    DivZero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
                    neg_q   <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                    neg_r   <= Dividend[WIDTH-1];
`endif
                    // Zero divisor skips CALC; results are published on the way to DONE.
                    if (Divisor == '0) begin
                        Quotient  <= '1;
                        Remainder <= Dividend;
                        DivZero   <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_nxt;
                    qr  <= q_fin;
                    if (last) begin
                        Quotient  <= q_out;
                        Remainder <= r_out;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: stimulus pushes expected results, a negedge monitor checks done.
module tb_divider_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] Dividend = '0, Divisor = '0;
    logic        busy, done, DivZero;
    logic [31:0] Quotient, Remainder;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    divider_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Dividend(Dividend), .Divisor(Divisor),
        .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder), .DivZero(DivZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation, at the expected cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", Quotient, e.q);
                chk("remainder", Remainder, e.r);
                chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    // Drive one request; edge E samples it. Inputs are scrambled afterwards.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input logic [31:0] r, input logic dz, input bit push, input bit sync);
        exp_t e;
        if (sync) @(negedge clk);
        Dividend = a; Divisor = b; start = 1'b1;
        @(posedge clk);
        #1;
        e.q = q; e.r = r; e.dz = dz;
        e.cyc = cyc + ((b == 32'd0) ? 0 : 32);
        if (push) sb.push_back(e);
        start = 1'b0;
        Dividend = $urandom; Divisor = $urandom;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", Quotient, 32'd0);
        chk("rst_r", Remainder, 32'd0);
        chk("rst_dz", {31'd0, DivZero}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1, 1);
        wait_idle();
        issue(32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, 1);
        wait_idle();
        issue(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1, 1);
        wait_idle();

        // Hold start through the whole operation: only one acceptance.
        @(negedge clk);
        Dividend = 32'd50; Divisor = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{q: 32'd10, r: 32'd0, dz: 1'b0, cyc: cyc + 32});
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_requeue_busy", {31'd0, busy}, 32'd0);
        chk("held_q_stable", Quotient, 32'd10);

`ifdef DIVIDER_SIGNED_EN
        issue(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1, 1);
        wait_idle();
        issue(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1, 1);
        wait_idle();
        issue(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1, 1);
        wait_idle();
`else
        issue(32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0, 1, 1);
        wait_idle();
        issue(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1, 1);
        wait_idle();
`endif
        issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1, 1);
        wait_idle();

        // Abort mid-calculation; no done may follow.
        issue(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, 0, 1);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", Quotient, 32'd0);
        chk("abort_r", Remainder, 32'd0);
        chk("abort_dz", {31'd0, DivZero}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1, 0);
        wait_idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
